// File: rtl/rpn_job_arbiter_if.sv
// Bus bundle for the RPN job arbiter: two requester ports, two response
// ports, the converter token link, the calculator result link and status.
//
// Handshake: a transfer happens on a rising edge where stb && ack are both
// high; a sender holds stb and its payload stable until acked, and a
// receiver never derives its ack from its own outgoing stb.
interface rpn_job_arbiter_if;
    // requester token ports
    logic        req0_stb;
    logic [31:0] req0_data;
    logic        req0_is_operator;
    logic        req0_ack;
    logic        req1_stb;
    logic [31:0] req1_data;
    logic        req1_is_operator;
    logic        req1_ack;
    // requester response ports
    logic        rsp0_stb;
    logic [63:0] rsp0_data;
    logic        rsp0_err;
    logic        rsp0_ack;
    logic        rsp1_stb;
    logic [63:0] rsp1_data;
    logic        rsp1_err;
    logic        rsp1_ack;
    // shared pipeline side
    logic        cnv_stb;
    logic [31:0] cnv_data;
    logic        cnv_is_operator;
    logic        cnv_ack;
    logic        calc_stb;
    logic [63:0] calc_data;
    logic        calc_ack;
    // status and FSM visibility
    logic        busy;
    logic        owner;
    logic [1:0]  dbg_state;

    // environment view: requesters, converter and calculator
    modport master (
        output req0_stb, req0_data, req0_is_operator,
        output req1_stb, req1_data, req1_is_operator,
        input  req0_ack, req1_ack,
        input  rsp0_stb, rsp0_data, rsp0_err,
        input  rsp1_stb, rsp1_data, rsp1_err,
        output rsp0_ack, rsp1_ack,
        input  cnv_stb, cnv_data, cnv_is_operator,
        output cnv_ack,
        output calc_stb, calc_data,
        input  calc_ack,
        input  busy, owner, dbg_state
    );

    // arbiter view
    modport slave (
        input  req0_stb, req0_data, req0_is_operator,
        input  req1_stb, req1_data, req1_is_operator,
        output req0_ack, req1_ack,
        output rsp0_stb, rsp0_data, rsp0_err,
        output rsp1_stb, rsp1_data, rsp1_err,
        input  rsp0_ack, rsp1_ack,
        output cnv_stb, cnv_data, cnv_is_operator,
        input  cnv_ack,
        input  calc_stb, calc_data,
        output calc_ack,
        output busy, owner, dbg_state
    );
endinterface

// File: rtl/rpn_job_arbiter.sv
// Round-robin arbiter sharing one converter->calculator RPN pipeline between
// two requesters. One whole expression is granted at a time; the result (or
// a watchdog error) is returned to the requester that owned the pipeline.
// CNT_W must satisfy 2**CNT_W > TIMEOUT_CYCLES.
module rpn_job_arbiter #(
    parameter logic [31:0] END_CODE       = 32'h0000_003D,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic             CLK,
    input  logic             RST,
    rpn_job_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FORWARD = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_DELIVER = 2'd3;

    logic [1:0]       r_state;
    logic             r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rsp0_stb;
    logic [63:0]      r_rsp0_data;
    logic             r_rsp0_err;
    logic             r_rsp1_stb;
    logic [63:0]      r_rsp1_data;
    logic             r_rsp1_err;

    logic             w_sel_stb;
    logic [31:0]      w_sel_data;
    logic             w_sel_op;
    logic             w_grant_valid;
    logic             w_grant_idx;
    logic             w_in_fwd;
    logic             w_end_xfer;
    logic             w_timeout;
    logic             w_calc_take;
    logic             w_to_fire;
    logic             w_rsp_done;

    // select the owner's token stream and decide the next grant
    always_comb begin
        w_sel_stb  = r_owner ? bus.req1_stb : bus.req0_stb;
        w_sel_data = r_owner ? bus.req1_data : bus.req0_data;
        w_sel_op   = r_owner ? bus.req1_is_operator : bus.req0_is_operator;
        w_grant_valid = bus.req0_stb | bus.req1_stb;
        // on a tie the requester that did not win last time goes first
        if (bus.req0_stb && bus.req1_stb) begin
            w_grant_idx = ~r_owner;
        end else begin
            w_grant_idx = bus.req1_stb;
        end
    end

    // state-qualified events
    always_comb begin
        w_in_fwd    = (r_state == S_FORWARD);
        w_end_xfer  = w_in_fwd && w_sel_stb && bus.cnv_ack &&
                      w_sel_op && (w_sel_data == END_CODE);
        w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        w_calc_take = (r_state == S_WAIT) && bus.calc_stb;
        // a result arriving on the timeout cycle still wins
        w_to_fire   = (r_state == S_WAIT) && !bus.calc_stb && w_timeout;
        w_rsp_done  = (r_state == S_DELIVER) &&
                      (r_owner ? bus.rsp1_ack : bus.rsp0_ack);
    end

    // combinational pass-through to the converter and ack routing
    always_comb begin
        bus.cnv_stb         = w_in_fwd && w_sel_stb;
        bus.cnv_data        = w_in_fwd ? w_sel_data : 32'd0;
        bus.cnv_is_operator = w_in_fwd && w_sel_op;
        bus.req0_ack        = w_in_fwd && !r_owner && bus.cnv_ack;
        bus.req1_ack        = w_in_fwd &&  r_owner && bus.cnv_ack;
        // results are taken (and dropped unless awaited) outside DELIVER
        bus.calc_ack        = RST && (r_state != S_DELIVER) && bus.calc_stb;
        bus.rsp0_stb        = r_rsp0_stb;
        bus.rsp0_data       = r_rsp0_data;
        bus.rsp0_err        = r_rsp0_err;
        bus.rsp1_stb        = r_rsp1_stb;
        bus.rsp1_data       = r_rsp1_data;
        bus.rsp1_err        = r_rsp1_err;
        bus.busy            = (r_state != S_IDLE);
        bus.owner           = r_owner;
        bus.dbg_state       = r_state;
    end

    // expression FSM, ownership and watchdog counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_owner <= 1'b1;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_owner <= w_grant_idx;
                        r_state <= S_FORWARD;
                    end
                end
                S_FORWARD: begin
                    if (w_end_xfer) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_calc_take || w_to_fire) begin
                        r_state <= S_DELIVER;
                    end
                end
                default: begin
                    if (w_rsp_done) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // response registers for the owning requester
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rsp0_stb  <= 1'b0;
            r_rsp0_data <= 64'd0;
            r_rsp0_err  <= 1'b0;
            r_rsp1_stb  <= 1'b0;
            r_rsp1_data <= 64'd0;
            r_rsp1_err  <= 1'b0;
        end else if (w_calc_take || w_to_fire) begin
            if (!r_owner) begin
                r_rsp0_stb  <= 1'b1;
                r_rsp0_data <= w_calc_take ? bus.calc_data : 64'd0;
                r_rsp0_err  <= w_to_fire;
            end else begin
                r_rsp1_stb  <= 1'b1;
                r_rsp1_data <= w_calc_take ? bus.calc_data : 64'd0;
                r_rsp1_err  <= w_to_fire;
            end
        end else if (w_rsp_done) begin
            if (!r_owner) begin
                r_rsp0_stb <= 1'b0;
                r_rsp0_err <= 1'b0;
            end else begin
                r_rsp1_stb <= 1'b0;
                r_rsp1_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rpn_job_arbiter.sv
// Bench for rpn_job_arbiter: requester drivers, converter/calculator models,
// a negedge monitor with expected queues, and a final report.
module tb_rpn_job_arbiter;

    localparam int          TIMEOUT  = 1024;
    localparam logic [31:0] END_CODE = 32'h0000_003D;
    localparam logic [31:0] OP_ADD   = 32'h0000_002B;
    localparam logic [31:0] OP_MUL   = 32'h0000_002A;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cnv_ack_en = 1'b1;
    logic rsp_ack0_en = 1'b1;
    logic rsp_ack1_en = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;

    logic [32:0] tok0_q[$];
    logic [32:0] tok1_q[$];
    logic [64:0] rsp0_q[$];
    logic [64:0] rsp1_q[$];
    logic [63:0] calc0_q[$];
    logic [63:0] calc1_q[$];
    logic        exp_own_q[$];

    bit   prev_busy, prev_r0, prev_r1, have_own, end_seen;
    logic cur_own, end_own;
    int   end_edge, calc_edge;

    rpn_job_arbiter_if bif ();

    assign bif.cnv_ack  = cnv_ack_en;
    assign bif.rsp0_ack = rsp_ack0_en;
    assign bif.rsp1_ack = rsp_ack1_en;

    rpn_job_arbiter #(
        .END_CODE(END_CODE),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_W(11)
    ) dut (
        .CLK(clk),
        .RST(rst_n),
        .bus(bif)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_model();
        tok0_q.delete(); tok1_q.delete();
        rsp0_q.delete(); rsp1_q.delete();
        calc0_q.delete(); calc1_q.delete();
        exp_own_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bif.req0_stb = 0; bif.req0_data = 0; bif.req0_is_operator = 0;
        bif.req1_stb = 0; bif.req1_data = 0; bif.req1_is_operator = 0;
        bif.calc_stb = 0; bif.calc_data = 0;
        cnv_ack_en = 1; rsp_ack0_en = 1; rsp_ack1_en = 1;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // drive one token on port p and hold it until accepted
    task automatic send_tok(input int p, input logic [31:0] d, input logic op);
        int   n = 0;
        logic acked = 0;
        if (p == 0) begin
            tok0_q.push_back({op, d});
            bif.req0_data = d; bif.req0_is_operator = op; bif.req0_stb = 1;
        end else begin
            tok1_q.push_back({op, d});
            bif.req1_data = d; bif.req1_is_operator = op; bif.req1_stb = 1;
        end
        do begin
            @(negedge clk);
            acked = (p == 0) ? bif.req0_ack : bif.req1_ack;
            n++;
        end while (!acked && n < 4000);
        if (!acked) chk("req_ack_wait", 0, 1);
        @(posedge clk);
        #1;
        if (p == 0) bif.req0_stb = 0; else bif.req1_stb = 0;
    endtask

    // "a b op =" expression; with_calc=0 means the calculator stays silent
    task automatic send_expr(input int p, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] op, input bit with_calc);
        logic [63:0] res;
        res = (op == OP_ADD) ? (64'(a) + 64'(b)) : (64'(a) * 64'(b));
        if (with_calc) begin
            if (p == 0) begin calc0_q.push_back(res); rsp0_q.push_back({1'b0, res}); end
            else        begin calc1_q.push_back(res); rsp1_q.push_back({1'b0, res}); end
        end else begin
            if (p == 0) rsp0_q.push_back({1'b1, 64'd0});
            else        rsp1_q.push_back({1'b1, 64'd0});
        end
        send_tok(p, a, 1'b0);
        send_tok(p, b, 1'b0);
        send_tok(p, op, 1'b1);
        send_tok(p, END_CODE, 1'b1);
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while ((rsp0_q.size() != 0 || rsp1_q.size() != 0 || bif.busy) && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (n >= lim) chk("drain_wait", 1, 0);
    endtask

    // calculator model: answers two cycles after the END token is forwarded
    initial forever begin
        logic [63:0] val;
        bit          have;
        int          n;
        @(posedge clk);
        if (end_seen) begin
            end_seen = 0;
            have = 0;
            if (end_own == 1'b0 && calc0_q.size() != 0) begin val = calc0_q.pop_front(); have = 1; end
            if (end_own == 1'b1 && calc1_q.size() != 0) begin val = calc1_q.pop_front(); have = 1; end
            if (have) begin
                @(posedge clk);
                #1 bif.calc_stb = 1; bif.calc_data = val;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!bif.calc_ack && n < 100);
                if (!bif.calc_ack) chk("calc_ack_wait", 0, 1);
                @(posedge clk);
                #1 bif.calc_stb = 0; bif.calc_data = 0;
            end
        end
    end

    // monitor / scoreboard
    initial forever begin
        logic [32:0] et;
        logic [64:0] er;
        @(negedge clk);
        if (!rst_n) begin
            prev_busy = 0; prev_r0 = 0; prev_r1 = 0; have_own = 0;
        end else begin
            if (bif.busy && !prev_busy) begin
                if (exp_own_q.size() == 0) chk("grant_unexpected", 1, 0);
                else begin
                    cur_own = exp_own_q.pop_front();
                    have_own = 1;
                    chk("grant_owner", bif.owner, cur_own);
                end
            end
            if (bif.busy && have_own)
                chk("nonowner_ack", cur_own ? bif.req0_ack : bif.req1_ack, 0);
            if (bif.cnv_stb && bif.cnv_ack) begin
                if (cur_own == 1'b0 && tok0_q.size() != 0) et = tok0_q.pop_front();
                else if (cur_own == 1'b1 && tok1_q.size() != 0) et = tok1_q.pop_front();
                else et = 33'h1_FFFF_FFFF;
                chk("cnv_token", {bif.cnv_is_operator, bif.cnv_data}, et);
                if (bif.cnv_is_operator && bif.cnv_data == END_CODE) begin
                    end_edge = cyc + 1;
                    end_own  = cur_own;
                    end_seen = 1;
                end
            end
            if (bif.calc_stb && bif.calc_ack) calc_edge = cyc + 1;
            // response port 0
            if (bif.rsp0_stb && !prev_r0) begin
                if (rsp0_q.size() == 0) chk("rsp0_unexpected", 1, 0);
                else if (rsp0_q[0][64]) chk("timeout_latency", 65'(cyc - end_edge), 65'(TIMEOUT));
                else chk("rsp0_latency", 65'(cyc - calc_edge), 0);
            end
            if (bif.rsp0_stb && bif.rsp0_ack && rsp0_q.size() != 0) begin
                er = rsp0_q.pop_front();
                chk("rsp0_result", {bif.rsp0_err, bif.rsp0_data}, er);
            end
            // response port 1
            if (bif.rsp1_stb && !prev_r1) begin
                if (rsp1_q.size() == 0) chk("rsp1_unexpected", 1, 0);
                else if (rsp1_q[0][64]) chk("timeout_latency", 65'(cyc - end_edge), 65'(TIMEOUT));
                else chk("rsp1_latency", 65'(cyc - calc_edge), 0);
            end
            if (bif.rsp1_stb && bif.rsp1_ack && rsp1_q.size() != 0) begin
                er = rsp1_q.pop_front();
                chk("rsp1_result", {bif.rsp1_err, bif.rsp1_data}, er);
            end
            prev_busy = bif.busy;
            prev_r0   = bif.rsp0_stb;
            prev_r1   = bif.rsp1_stb;
        end
    end

    // global time limit
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

    // test sequence
    initial begin
        do_reset();
        #1;
        chk("rst_busy", bif.busy, 0);
        chk("rst_owner", bif.owner, 1);
        chk("rst_cnv_stb", bif.cnv_stb, 0);
        chk("rst_cnv_data", bif.cnv_data, 0);
        chk("rst_req_ack", {bif.req0_ack, bif.req1_ack}, 0);
        chk("rst_rsp_stb", {bif.rsp0_stb, bif.rsp1_stb}, 0);
        chk("rst_rsp_err", {bif.rsp0_err, bif.rsp1_err}, 0);
        chk("rst_rsp0_data", bif.rsp0_data, 0);
        chk("rst_rsp1_data", bif.rsp1_data, 0);
        chk("rst_calc_ack", bif.calc_ack, 0);

        // single requester: 3 4 + =  -> 7
        exp_own_q.push_back(0);
        send_expr(0, 3, 4, OP_ADD, 1);
        drain(200);

        // both requesting from reset: owners 0,1,0,1
        do_reset();
        exp_own_q.push_back(0); exp_own_q.push_back(1);
        exp_own_q.push_back(0); exp_own_q.push_back(1);
        fork
            begin send_expr(0, 1, 2, OP_ADD, 1); send_expr(0, 5, 6, OP_MUL, 1); end
            begin send_expr(1, 7, 8, OP_ADD, 1); send_expr(1, 9, 3, OP_MUL, 1); end
        join
        drain(400);

        // converter backpressure mid-stream while req1 also waits
        exp_own_q.push_back(0); exp_own_q.push_back(1);
        fork
            send_expr(0, 10, 20, OP_MUL, 1);
            send_expr(1, 11, 12, OP_ADD, 1);
            begin
                repeat (2) @(posedge clk);
                #1 cnv_ack_en = 0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_req0_ack", bif.req0_ack, 0);
                    chk("bp_req1_ack", bif.req1_ack, 0);
                    chk("bp_cnv_stb", bif.cnv_stb, 1);
                end
                @(posedge clk);
                #1 cnv_ack_en = 1;
            end
        join
        drain(400);

        // watchdog: calculator never answers
        exp_own_q.push_back(0);
        send_expr(0, 2, 2, OP_ADD, 0);
        drain(3000);

        // late result in IDLE is acked and dropped
        @(posedge clk);
        #1 bif.calc_stb = 1; bif.calc_data = 64'd99;
        @(negedge clk);
        chk("stale_calc_ack", bif.calc_ack, 1);
        chk("stale_busy", bif.busy, 0);
        @(posedge clk);
        #1 bif.calc_stb = 0; bif.calc_data = 0;
        exp_own_q.push_back(1);
        send_expr(1, 5, 6, OP_ADD, 1);
        drain(200);

        // response held off: stable output, no calc_ack, no new grant
        rsp_ack1_en = 0;
        exp_own_q.push_back(1); exp_own_q.push_back(0);
        send_expr(1, 8, 9, OP_ADD, 1);
        begin
            int n = 0;
            while (!bif.rsp1_stb && n < 100) begin @(negedge clk); n++; end
            chk("hold_rsp1_seen", bif.rsp1_stb, 1);
        end
        fork
            send_expr(0, 2, 3, OP_ADD, 1);
        join_none
        @(posedge clk);
        #1 bif.calc_stb = 1; bif.calc_data = 64'd55;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_rsp1_stb", bif.rsp1_stb, 1);
            chk("hold_rsp1_data", bif.rsp1_data, 17);
            chk("hold_calc_ack", bif.calc_ack, 0);
            chk("hold_owner", bif.owner, 1);
            chk("hold_req0_ack", bif.req0_ack, 0);
        end
        @(posedge clk);
        #1 bif.calc_stb = 0; bif.calc_data = 0;
        rsp_ack1_en = 1;
        drain(400);

        // asynchronous reset in FORWARD after two tokens
        exp_own_q.push_back(0);
        send_tok(0, 32'd3, 1'b0);
        send_tok(0, 32'd4, 1'b0);
        cnv_ack_en = 0;
        bif.req0_data = OP_ADD; bif.req0_is_operator = 1; bif.req0_stb = 1;
        @(negedge clk);
        chk("pre_rst_cnv_stb", bif.cnv_stb, 1);
        @(posedge clk);
        #2 cnv_ack_en = 1; rst_n = 0;
        #1;
        chk("arst_busy", bif.busy, 0);
        chk("arst_cnv_stb", bif.cnv_stb, 0);
        chk("arst_cnv_data", bif.cnv_data, 0);
        chk("arst_req0_ack", bif.req0_ack, 0);
        chk("arst_owner", bif.owner, 1);
        chk("arst_state", bif.dbg_state, 0);
        bif.req0_stb = 0; bif.req0_data = 0; bif.req0_is_operator = 0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        exp_own_q.push_back(0);
        send_expr(0, 6, 7, OP_MUL, 1);
        drain(200);

        repeat (5) @(negedge clk);
        chk("leftover_tok", 65'(tok0_q.size() + tok1_q.size()), 0);
        chk("leftover_rsp", 65'(rsp0_q.size() + rsp1_q.size()), 0);
        chk("leftover_grant", 65'(exp_own_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
